// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared types and constants for the unified memory arbiter:
//   owner_e       - which requester issued a read (fetch or data port)
//   tag_t         - one entry of the read-latency tag pipe {valid, owner}
//   MEM_LAT_MIN/MAX, mem_lat_legal() - legal range of the memory read latency
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// ----------------------------------------------------------------------------
// mem_arb_tag_pipe
//
// MEM_LAT-deep shift register of read tags. A tag pushed in the grant cycle
// appears on exit_tag exactly MEM_LAT rising edges later, which is when the
// backing memory presents the matching read data.
//
// Ports:
//   clk       in  clock
//   reset     in  asynchronous active-low clear of every tag
//   push_tag  in  tag entering the pipe this cycle (valid=0 when no read)
//   exit_tag  out tag leaving the pipe this cycle
//   busy      out at least one valid tag is in flight
// ----------------------------------------------------------------------------
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t push_tag,
  output tag_t exit_tag,
  output logic busy
);

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_lat
    $error("mem_arb_tag_pipe: MEM_LAT out of range 1..4");
  end

  tag_t tag_p [MEM_LAT];

  // Stage boundary: one register per cycle of memory read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_p[i] <= '0;
      end
    end else begin
      tag_p[0] <= push_tag;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign exit_tag = tag_p[MEM_LAT-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) begin
      busy = busy | tag_p[i].valid;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported word memory between the instruction-fetch port and
// the data port of the pipeline. At most one access is granted per cycle; the
// grant drives the memory strobes combinationally. Read ownership is carried
// through a MEM_LAT-deep tag pipe so returning data is flagged to the port
// that issued it.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> on contention grant the port not granted
//                                    most recently (1-bit pointer).
//                       undefined -> fixed priority, data over fetch.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch read request and byte address
//   if_gnt                     fetch request accepted this cycle
//   if_rvalid/if_rdata         fetch read return
//   d_req/d_we/d_addr          data request, write flag, byte address
//   d_wdata/d_wbyte            write data and byte strobe
//   d_gnt                      data request accepted this cycle
//   d_rvalid/d_rdata           data read return
//   m_read_ready/m_read_address                 memory read strobe, word addr
//   m_write_ready/m_write_address               memory write strobe, word addr
//   m_write_data/m_write_byte                   memory write data, byte strobe
//   m_read_data                memory read data, MEM_LAT cycles after strobe
//   busy                       at least one read outstanding
// ----------------------------------------------------------------------------
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wbyte,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_read_ready,
  output logic [ADDR_W-3:0] m_read_address,
  output logic              m_write_ready,
  output logic [ADDR_W-3:0] m_write_address,
  output logic [31:0]       m_write_data,
  output logic [3:0]        m_write_byte,
  input  logic [31:0]       m_read_data,
  output logic              busy
);

  // Byte-lane bits of the requester addresses are not used by a word memory.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{if_addr[1:0], d_addr[1:0]};

  // --------------------------------------------------------------------------
  // Arbitration. Grants are held off while reset is asserted so every output
  // is 0 during reset even with requests pending.
  // --------------------------------------------------------------------------
  logic d_wins;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner;

  // Data wins when fetch is not asking, or when fetch was granted last.
  assign d_wins = !if_req || (last_owner == OWNER_IF);

  // Reset to fetch-last so data wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWNER_IF;
    end else if (d_gnt) begin
      last_owner <= OWNER_D;
    end else if (if_gnt) begin
      last_owner <= OWNER_IF;
    end
  end
`else
  assign d_wins = 1'b1;
`endif

  always_comb begin
    d_gnt  = reset & d_req & d_wins;
    if_gnt = reset & if_req & ~d_gnt;
  end

  // --------------------------------------------------------------------------
  // Memory request mux; everything is 0 when nothing is granted.
  // --------------------------------------------------------------------------
  tag_t push_tag;

  always_comb begin
    m_read_ready    = 1'b0;
    m_read_address  = '0;
    m_write_ready   = 1'b0;
    m_write_address = '0;
    m_write_data    = '0;
    m_write_byte    = '0;
    push_tag        = '0;
    if (d_gnt && d_we) begin
      m_write_ready   = 1'b1;
      m_write_address = d_addr[ADDR_W-1:2];
      m_write_data    = d_wdata;
      m_write_byte    = d_wbyte;
    end else if (d_gnt) begin
      m_read_ready   = 1'b1;
      m_read_address = d_addr[ADDR_W-1:2];
      push_tag.valid = 1'b1;
      push_tag.owner = OWNER_D;
    end else if (if_gnt) begin
      m_read_ready   = 1'b1;
      m_read_address = if_addr[ADDR_W-1:2];
      push_tag.valid = 1'b1;
      push_tag.owner = OWNER_IF;
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding-read tracking.
  // --------------------------------------------------------------------------
  tag_t exit_tag;

  mem_arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .push_tag (push_tag),
    .exit_tag (exit_tag),
    .busy     (busy)
  );

  // --------------------------------------------------------------------------
  // Return demux. Read data fans out to both ports; each consumer qualifies
  // it with its own rvalid. Data is forced to 0 only while in reset.
  // --------------------------------------------------------------------------
  always_comb begin
    if_rvalid = exit_tag.valid && (exit_tag.owner == OWNER_IF);
    d_rvalid  = exit_tag.valid && (exit_tag.owner == OWNER_D);
    if_rdata  = reset ? m_read_data : 32'h0;
    d_rdata   = reset ? m_read_data : 32'h0;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Two arbiters (MEM_LAT=1 and MEM_LAT=3) share one stimulus stream, each with
// its own behavioural word memory of matching latency. Directed vectors with
// hand-computed expectations, plus sequences for contention, back-to-back
// reads and reset during an outstanding read.
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wbyte;

  // MEM_LAT = 1 instance
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, busy1;
  logic [31:0] if_rdata1, d_rdata1;
  logic        m_rr1, m_wr1;
  logic [29:0] m_ra1, m_wa1;
  logic [31:0] m_wd1, m_rdata1;
  logic [3:0]  m_wb1;

  // MEM_LAT = 3 instance
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, busy3;
  logic [31:0] if_rdata3, d_rdata3;
  logic        m_rr3, m_wr3;
  logic [29:0] m_ra3, m_wa3;
  logic [31:0] m_wd3, m_rdata3;
  logic [3:0]  m_wb3;

  int checks;
  int errors;

  unified_mem_arbiter #(.MEM_LAT(1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wbyte(d_wbyte), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_read_ready(m_rr1), .m_read_address(m_ra1),
    .m_write_ready(m_wr1), .m_write_address(m_wa1),
    .m_write_data(m_wd1), .m_write_byte(m_wb1),
    .m_read_data(m_rdata1), .busy(busy1)
  );

  unified_mem_arbiter #(.MEM_LAT(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wbyte(d_wbyte), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_read_ready(m_rr3), .m_read_address(m_ra3),
    .m_write_ready(m_wr3), .m_write_address(m_wa3),
    .m_write_data(m_wd3), .m_write_byte(m_wb3),
    .m_read_data(m_rdata3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories: 256 words, byte-write strobes, fixed read latency.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rp1;
  logic [31:0] rp3 [3];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h1000_0000 + i;
      mem3[i] = 32'h1000_0000 + i;
    end
    rp1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) rp3[i] = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (m_wr1)
      for (int b = 0; b < 4; b++)
        if (m_wb1[b]) mem1[m_wa1[7:0]][8*b +: 8] <= m_wd1[8*b +: 8];
    if (m_rr1) rp1 <= mem1[m_ra1[7:0]];
  end

  always @(posedge clk) begin
    if (m_wr3)
      for (int b = 0; b < 4; b++)
        if (m_wb3[b]) mem3[m_wa3[7:0]][8*b +: 8] <= m_wd3[8*b +: 8];
    rp3[0] <= m_rr3 ? mem3[m_ra3[7:0]] : 32'hDEAD_BEEF;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  assign m_rdata1 = rp1;
  assign m_rdata3 = rp3[2];

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da,
                       input logic [31:0] wd, input logic [3:0] wb);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = wd;
    d_wbyte = wb;
  endtask

  task automatic set_idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // {if_gnt, d_gnt, rr, ra, wr, wa, wd, wb}
  function automatic logic [99:0] mk(input logic ig, input logic dg, input logic rr,
                                     input logic [29:0] ra, input logic wr,
                                     input logic [29:0] wa, input logic [31:0] wd,
                                     input logic [3:0] wb);
    return {ig, dg, rr, ra, wr, wa, wd, wb};
  endfunction

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  wb;
    logic [99:0] exp_comb;
    logic        exp_ifv;
    logic        exp_dv;
    logic        exp_busy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [9];
  logic [1:0]  exp_g [4];
  logic [1:0]  prev_g;
  logic [31:0] prev_d;
  logic        b2b_ifv [7];
  logic        b2b_dv [7];
  logic        b2b_busy [7];
  logic [31:0] b2b_data [7];

  initial begin
    checks = 0;
    errors = 0;

    vt[0] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              mk(0,0,0,30'h0,0,30'h0,32'h0,4'h0), 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              mk(1,0,1,30'h4,0,30'h0,32'h0,4'h0), 1'b0, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0011,
              mk(0,1,0,30'h0,1,30'h8,32'hAABBCCDD,4'b0011), 1'b1, 1'b0, 1'b1, 32'h1000_0004};
    vt[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0,
              mk(0,1,1,30'h8,0,30'h0,32'h0,4'h0), 1'b0, 1'b0, 1'b0, 32'h0};
    vt[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h47, 32'h12345678, 4'hF,
              mk(0,1,0,30'h0,1,30'h11,32'h12345678,4'hF), 1'b0, 1'b1, 1'b1, 32'h1000_CCDD};
    vt[5] = '{1'b1, 32'h46, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              mk(1,0,1,30'h11,0,30'h0,32'h0,4'h0), 1'b0, 1'b0, 1'b0, 32'h0};
    vt[6] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              mk(1,0,1,30'h3FFF_FFFF,0,30'h0,32'h0,4'h0), 1'b1, 1'b0, 1'b1, 32'h1234_5678};
    vt[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              mk(0,0,0,30'h0,0,30'h0,32'h0,4'h0), 1'b1, 1'b0, 1'b1, 32'h1000_00FF};
    // Qualifiers present without a request: nothing may reach the memory.
    vt[8] = '{1'b0, 32'h30, 1'b0, 1'b1, 32'h30, 32'h55555555, 4'hF,
              mk(0,0,0,30'h0,0,30'h0,32'h0,4'h0), 1'b0, 1'b0, 1'b0, 32'h0};

`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    b2b_ifv  = '{0, 0, 0, 1, 0, 1, 0};
    b2b_dv   = '{0, 0, 0, 0, 1, 0, 0};
    b2b_busy = '{0, 1, 1, 1, 1, 1, 0};
    b2b_data = '{32'h0, 32'h0, 32'h0, 32'h1000_0004, 32'h1000_CCDD, 32'h1234_5678, 32'h0};

    // Reset held with both ports requesting: every output stays 0.
    reset = 1'b1;
    drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 reset = 1'b0;
    tick();
    tick();
    chk("reset_outputs_lat1",
        {if_gnt1, if_rvalid1, if_rdata1, d_gnt1, d_rvalid1, d_rdata1, m_rr1, m_ra1,
         m_wr1, m_wa1, m_wd1, m_wb1, busy1}, 256'h0);
    chk("reset_outputs_lat3",
        {if_gnt3, if_rvalid3, if_rdata3, d_gnt3, d_rvalid3, d_rdata3, m_rr3, m_ra3,
         m_wr3, m_wa3, m_wd3, m_wb3, busy3}, 256'h0);

    // Release: data wins the very first cycle.
    reset = 1'b1;
    #1;
    chk("first_gnt_after_reset", {if_gnt1, d_gnt1, if_gnt3, d_gnt3}, 4'b0101);
    tick();
    set_idle();
    for (int i = 0; i < 5; i++) tick();

    // Table vectors, one per cycle, checked mid-cycle.
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dw, vt[i].da, vt[i].wd, vt[i].wb);
      #1;
      chk($sformatf("vec%0d_comb_lat1", i),
          mk(if_gnt1, d_gnt1, m_rr1, m_ra1, m_wr1, m_wa1, m_wd1, m_wb1), vt[i].exp_comb);
      chk($sformatf("vec%0d_comb_lat3", i),
          mk(if_gnt3, d_gnt3, m_rr3, m_ra3, m_wr3, m_wa3, m_wd3, m_wb3), vt[i].exp_comb);
      chk($sformatf("vec%0d_rvalid_busy", i), {if_rvalid1, d_rvalid1, busy1},
          {vt[i].exp_ifv, vt[i].exp_dv, vt[i].exp_busy});
      if (vt[i].exp_ifv) chk($sformatf("vec%0d_if_rdata", i), if_rdata1, vt[i].exp_rdata);
      if (vt[i].exp_dv)  chk($sformatf("vec%0d_d_rdata", i), d_rdata1, vt[i].exp_rdata);
      tick();
    end
    set_idle();
    for (int i = 0; i < 4; i++) tick();

    // Contention: lone fetch first so the pointer (if any) says fetch-last.
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    prev_g = 2'b10;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      else set_idle();
      #1;
      if (k < 4) chk($sformatf("contend_gnt%0d", k), {if_gnt1, d_gnt1}, exp_g[k]);
      prev_d = prev_g[1] ? 32'h1000_0001 : 32'h1000_0000;
      chk($sformatf("contend_ret%0d", k),
          {if_rvalid1, d_rvalid1, (prev_g[1] ? if_rdata1 : d_rdata1)}, {prev_g, prev_d});
      if (k < 4) prev_g = exp_g[k];
      tick();
    end
    set_idle();
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back reads IF, D, IF on the MEM_LAT=3 instance.
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        1: drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        2: drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        default: set_idle();
      endcase
      #1;
      chk($sformatf("b2b_c%0d_valid_busy", c), {if_rvalid3, d_rvalid3, busy3},
          {b2b_ifv[c], b2b_dv[c], b2b_busy[c]});
      if (b2b_ifv[c]) chk($sformatf("b2b_c%0d_if_rdata", c), if_rdata3, b2b_data[c]);
      if (b2b_dv[c])  chk($sformatf("b2b_c%0d_d_rdata", c), d_rdata3, b2b_data[c]);
      tick();
    end
    set_idle();
    for (int i = 0; i < 3; i++) tick();

    // Reset one cycle after a read grant: no return, busy drops at once.
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("midreset_grant", {if_gnt3, m_rr3}, 2'b11);
    tick();
    set_idle();
    reset = 1'b0;
    #1;
    chk("midreset_busy_clear", {busy1, busy3, if_rvalid1, if_rvalid3}, 4'b0000);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("midreset_no_rvalid%0d", c),
          {if_rvalid1, d_rvalid1, if_rvalid3, d_rvalid3, busy3}, 5'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
